wb_stage_q: RTL and testbench

WB_STAGE_Q -- requirements
Module: wb_stage_q

---
 rtl/riscv_wb_pkg.sv | 10 +
 rtl/mmr_fifo.sv | 56 +++++
 rtl/wb_stage_q.sv | 102 ++++++++++
 tb/tb_wb_stage_q.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared defaults for the writeback stage: datapath widths, MMR queue depth
// and the hard-wired zero register index.
package riscv_wb_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int MMR_DEPTH_DEF  = 4;
    localparam int ZERO_REG       = 0;

endpackage

// File: rtl/mmr_fifo.sv
// First-word-fall-through queue for MMR writes. The head entry is presented
// combinationally from storage; the storage array itself is never reset.
module mmr_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard both ports locally so the occupancy can never leave 0..DEPTH.
    assign push_ok = push & (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/wb_stage_q.sv
// Writeback stage: registers the register-file write for one cycle and queues
// MMR writes so a stalled MMR consumer never blocks the pipeline unseen.
module wb_stage_q
    import riscv_wb_pkg::*;
#(
    parameter  int XLEN       = XLEN_DEF,
    parameter  int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter  int MMR_DEPTH  = MMR_DEPTH_DEF,
    localparam int CNT_W      = $clog2(MMR_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic                  we,
    input  logic [XLEN-1:0]       rd_data_from_mem,
    input  logic [REG_ADDR_W-1:0] rd_addr_from_mem,
    input  logic [31:0]           inst_from_MEM,
    input  logic                  mmr_we_wb,
    input  logic [XLEN-1:0]       mmr_location,
    input  logic [XLEN-1:0]       loadnoc_data,
    output logic                  rf_we,
    output logic [XLEN-1:0]       rd_data_out_to_register,
    output logic [REG_ADDR_W-1:0] rd_addr_to_register,
    output logic [31:0]           inst_from_WB,
    output logic                  mmr_valid,
    input  logic                  mmr_ready,
    output logic [XLEN-1:0]       mmr_location_out,
    output logic [XLEN-1:0]       loadnoc_data_out_to_MMR,
    output logic [CNT_W-1:0]      mmr_count,
    output logic                  mmr_overflow
);

    logic                  rf_we_q, rf_we_d;
    logic [XLEN-1:0]       rd_data_q, rd_data_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [31:0]           inst_q, inst_d;
    logic                  overflow_q, overflow_d;
    logic                  accept;
    logic                  wen;
    logic [CNT_W-1:0]      count;
    logic [2*XLEN-1:0]     head;

    // Ready depends only on registered occupancy, so no mmr_ready->wb_ready path.
    assign wb_ready = (count != CNT_W'(MMR_DEPTH));
    assign accept   = wb_valid & wb_ready;
    assign wen      = we & (rd_addr_from_mem != REG_ADDR_W'(ZERO_REG));

    always_comb begin
        rf_we_d    = 1'b0;
        rd_data_d  = rd_data_q;
        rd_addr_d  = rd_addr_q;
        inst_d     = inst_q;
        overflow_d = overflow_q | (wb_valid & ~wb_ready);
        if (accept) begin
            rf_we_d   = wen;
            rd_data_d = wen ? rd_data_from_mem : '0;
            rd_addr_d = rd_addr_from_mem;
            inst_d    = inst_from_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            inst_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            inst_q     <= inst_d;
            overflow_q <= overflow_d;
        end
    end

    mmr_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (MMR_DEPTH)
    ) u_mmr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept & mmr_we_wb),
        .push_data ({mmr_location, loadnoc_data}),
        .pop       (mmr_valid & mmr_ready),
        .head_data (head),
        .count     (count)
    );

    assign rf_we                   = rf_we_q;
    assign rd_data_out_to_register = rd_data_q;
    assign rd_addr_to_register     = rd_addr_q;
    assign inst_from_WB            = inst_q;
    assign mmr_valid               = (count != '0);
    assign mmr_location_out        = head[2*XLEN-1:XLEN];
    assign loadnoc_data_out_to_MMR = head[XLEN-1:0];
    assign mmr_count               = count;
    assign mmr_overflow            = overflow_q;

endmodule

// File: tb/tb_wb_stage_q.sv
// Directed and scoreboarded bench for wb_stage_q with default parameters.
module tb_wb_stage_q;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int DEPTH = 4;
    localparam int CW   = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_valid, wb_ready, we, mmr_we_wb, mmr_ready;
    logic [XLEN-1:0] rd_data_from_mem, mmr_location, loadnoc_data;
    logic [RAW-1:0]  rd_addr_from_mem;
    logic [31:0]     inst_from_MEM;
    logic            rf_we, mmr_valid, mmr_overflow;
    logic [XLEN-1:0] rd_data_out_to_register, mmr_location_out, loadnoc_data_out_to_MMR;
    logic [RAW-1:0]  rd_addr_to_register;
    logic [31:0]     inst_from_WB;
    logic [CW-1:0]   mmr_count;

    int checks = 0;
    int failures = 0;

    wb_stage_q #(.XLEN(XLEN), .REG_ADDR_W(RAW), .MMR_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .we(we), .rd_data_from_mem(rd_data_from_mem), .rd_addr_from_mem(rd_addr_from_mem),
        .inst_from_MEM(inst_from_MEM), .mmr_we_wb(mmr_we_wb), .mmr_location(mmr_location),
        .loadnoc_data(loadnoc_data), .rf_we(rf_we),
        .rd_data_out_to_register(rd_data_out_to_register),
        .rd_addr_to_register(rd_addr_to_register), .inst_from_WB(inst_from_WB),
        .mmr_valid(mmr_valid), .mmr_ready(mmr_ready), .mmr_location_out(mmr_location_out),
        .loadnoc_data_out_to_MMR(loadnoc_data_out_to_MMR), .mmr_count(mmr_count),
        .mmr_overflow(mmr_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; we = 1'b0; mmr_we_wb = 1'b0;
        rd_data_from_mem = '0; rd_addr_from_mem = '0; inst_from_MEM = '0;
        mmr_location = '0; loadnoc_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        mmr_ready = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we: got %0d want 0", rf_we); end
        checks++; if (rd_data_out_to_register !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", rd_data_out_to_register); end
        checks++; if (rd_addr_to_register !== 5'd0) begin failures++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr_to_register); end
        checks++; if (inst_from_WB !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h want 0", inst_from_WB); end
        checks++; if (mmr_valid !== 1'b0) begin failures++; $display("FAIL reset_mmr_valid: got %0d want 0", mmr_valid); end
        checks++; if (mmr_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", mmr_count); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL reset_wb_ready: got %0d want 1", wb_ready); end
        checks++; if (mmr_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0d want 0", mmr_overflow); end
    endtask

    task automatic test_write();
        wb_valid = 1'b1; we = 1'b1; rd_addr_from_mem = 5'd5;
        rd_data_from_mem = 32'hDEADBEEF; inst_from_MEM = 32'h00500293;
        tick();
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL write_rf_we: got %0d want 1", rf_we); end
        checks++; if (rd_addr_to_register !== 5'd5) begin failures++; $display("FAIL write_addr: got %0d want 5", rd_addr_to_register); end
        checks++; if (rd_data_out_to_register !== 32'hDEADBEEF) begin failures++; $display("FAIL write_data: got %h want deadbeef", rd_data_out_to_register); end
        checks++; if (inst_from_WB !== 32'h00500293) begin failures++; $display("FAIL write_inst: got %h want 00500293", inst_from_WB); end
        // write to x0 is suppressed
        rd_addr_from_mem = 5'd0; rd_data_from_mem = 32'h12345678; inst_from_MEM = 32'h00000013;
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_rf_we: got %0d want 0", rf_we); end
        checks++; if (rd_data_out_to_register !== 32'h0) begin failures++; $display("FAIL x0_data: got %h want 0", rd_data_out_to_register); end
        checks++; if (inst_from_WB !== 32'h00000013) begin failures++; $display("FAIL x0_inst: got %h want 00000013", inst_from_WB); end
        // we=0 to a nonzero register
        we = 1'b0; rd_addr_from_mem = 5'd3; rd_data_from_mem = 32'hCAFEF00D; inst_from_MEM = 32'h11111111;
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL nowe_rf_we: got %0d want 0", rf_we); end
        checks++; if (rd_data_out_to_register !== 32'h0) begin failures++; $display("FAIL nowe_data: got %h want 0", rd_data_out_to_register); end
        checks++; if (rd_addr_to_register !== 5'd3) begin failures++; $display("FAIL nowe_addr: got %0d want 3", rd_addr_to_register); end
        // idle cycle: rf_we drops, everything else holds
        wb_valid = 1'b0; we = 1'b1; rd_addr_from_mem = 5'd7; inst_from_MEM = 32'h22222222;
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL idle_rf_we: got %0d want 0", rf_we); end
        checks++; if (rd_addr_to_register !== 5'd3) begin failures++; $display("FAIL idle_addr: got %0d want 3", rd_addr_to_register); end
        checks++; if (inst_from_WB !== 32'h11111111) begin failures++; $display("FAIL idle_inst: got %h want 11111111", inst_from_WB); end
        idle_inputs();
    endtask

    task automatic test_queue_fill();
        mmr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; mmr_we_wb = 1'b1;
            mmr_location = 32'h1000 + 32'(4 * i); loadnoc_data = 32'hA0 + 32'(i);
            tick();
        end
        checks++; if (mmr_count !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d want 4", mmr_count); end
        checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL fill_wb_ready: got %0d want 0", wb_ready); end
        checks++; if (mmr_overflow !== 1'b0) begin failures++; $display("FAIL fill_no_overflow: got %0d want 0", mmr_overflow); end
        // one more request while full is a protocol violation and is ignored
        mmr_location = 32'h2000; loadnoc_data = 32'hFF;
        tick();
        idle_inputs();
        checks++; if (mmr_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0d want 1", mmr_overflow); end
        checks++; if (mmr_count !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d want 4", mmr_count); end
        tick();
        checks++; if (mmr_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0d want 1", mmr_overflow); end
        checks++; if (mmr_location_out !== 32'h1000) begin failures++; $display("FAIL hold_head: got %h want 1000", mmr_location_out); end
    endtask

    task automatic test_drain_order();
        mmr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mmr_valid !== 1'b1) begin failures++; $display("FAIL drain_valid%0d: got %0d want 1", i, mmr_valid); end
            checks++; if (mmr_location_out !== 32'h1000 + 32'(4 * i)) begin failures++; $display("FAIL drain_loc%0d: got %h want %h", i, mmr_location_out, 32'h1000 + 32'(4 * i)); end
            checks++; if (loadnoc_data_out_to_MMR !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL drain_data%0d: got %h want %h", i, loadnoc_data_out_to_MMR, 32'hA0 + 32'(i)); end
            tick();
        end
        checks++; if (mmr_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got %0d want 0", mmr_valid); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL drain_ready: got %0d want 1", wb_ready); end
        mmr_ready = 1'b0;
    endtask

    task automatic test_concurrent();
        mmr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'b1; mmr_we_wb = 1'b1;
            mmr_location = 32'h3000 + 32'(4 * i); loadnoc_data = 32'hB0 + 32'(i);
            tick();
        end
        checks++; if (mmr_count !== 3'd2) begin failures++; $display("FAIL conc_pre_count: got %0d want 2", mmr_count); end
        mmr_ready = 1'b1; mmr_location = 32'h3008; loadnoc_data = 32'hB2;
        checks++; if (mmr_location_out !== 32'h3000) begin failures++; $display("FAIL conc_oldest: got %h want 3000", mmr_location_out); end
        tick();
        wb_valid = 1'b0; mmr_we_wb = 1'b0;
        checks++; if (mmr_count !== 3'd2) begin failures++; $display("FAIL conc_count: got %0d want 2", mmr_count); end
        checks++; if (mmr_location_out !== 32'h3004) begin failures++; $display("FAIL conc_second: got %h want 3004", mmr_location_out); end
        tick();
        checks++; if (mmr_location_out !== 32'h3008 || loadnoc_data_out_to_MMR !== 32'hB2) begin failures++; $display("FAIL conc_last: got %h/%h want 3008/b2", mmr_location_out, loadnoc_data_out_to_MMR); end
        tick();
        checks++; if (mmr_valid !== 1'b0) begin failures++; $display("FAIL conc_empty: got %0d want 0", mmr_valid); end
        mmr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] sb[$];
        logic [63:0] exp;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 200 && cyc < 5000) begin
            mmr_ready = 1'($urandom_range(0, 1));
            checks++;
            if (mmr_valid !== (sb.size() != 0)) begin
                failures++; $display("FAIL bp_valid c%0d: got %0d want %0d", cyc, mmr_valid, sb.size() != 0);
            end
            if (mmr_valid && mmr_ready && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                if ({mmr_location_out, loadnoc_data_out_to_MMR} !== exp) begin
                    failures++; $display("FAIL bp_entry%0d: got %h want %h", got, {mmr_location_out, loadnoc_data_out_to_MMR}, exp);
                end
                got++;
            end
            idle_inputs();
            if (sent < 200 && wb_ready && $urandom_range(0, 3) != 0) begin
                wb_valid = 1'b1;
                mmr_we_wb = 1'($urandom_range(0, 4) != 0);
                mmr_location = $urandom; loadnoc_data = $urandom;
                if (mmr_we_wb) begin
                    sb.push_back({mmr_location, loadnoc_data});
                    sent++;
                end
            end
            tick();
            cyc++;
        end
        idle_inputs();
        checks++; if (got != 200) begin failures++; $display("FAIL bp_received: got %0d want 200", got); end
        checks++; if (mmr_count !== 3'd0) begin failures++; $display("FAIL bp_final_count: got %0d want 0", mmr_count); end
        checks++; if (mmr_overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow: got %0d want 0", mmr_overflow); end
        mmr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        mmr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; mmr_we_wb = 1'b1; we = 1'b1;
            rd_addr_from_mem = 5'd9; rd_data_from_mem = 32'h5555AAAA; inst_from_MEM = 32'h77777777;
            mmr_location = 32'h4000 + 32'(4 * i); loadnoc_data = 32'hC0 + 32'(i);
            tick();
        end
        idle_inputs();
        checks++; if (mmr_count !== 3'd3 || rf_we !== 1'b1) begin failures++; $display("FAIL rmid_pre: count %0d rf_we %0d want 3/1", mmr_count, rf_we); end
        reset = 1'b0;
        tick();
        checks++; if (mmr_valid !== 1'b0 || wb_ready !== 1'b1) begin failures++; $display("FAIL rmid_first_edge: valid %0d ready %0d want 0/1", mmr_valid, wb_ready); end
        tick();
        reset = 1'b1;
        checks++; if (rf_we !== 1'b0 || rd_data_out_to_register !== 32'h0) begin failures++; $display("FAIL rmid_rf: rf_we %0d data %h want 0/0", rf_we, rd_data_out_to_register); end
        checks++; if (rd_addr_to_register !== 5'd0 || inst_from_WB !== 32'h0) begin failures++; $display("FAIL rmid_addr_inst: %0d/%h want 0/0", rd_addr_to_register, inst_from_WB); end
        checks++; if (mmr_count !== 3'd0 || mmr_valid !== 1'b0) begin failures++; $display("FAIL rmid_queue: count %0d valid %0d want 0/0", mmr_count, mmr_valid); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %0d want 1", wb_ready); end
    endtask

    initial begin
        reset = 1'b0;
        mmr_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_write();
        test_queue_fill();
        test_drain_order();
        apply_reset();
        test_concurrent();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
